// File: rtl/ysyx_22041752_mem_arbiter_pkg.sv
// Shared constants for the IF/LS memory arbiter: FSM state encodings, owner codes,
// default widths and a small owner helper.
package ysyx_22041752_mem_arbiter_pkg;

   localparam int SRAM_ADDR_WD = 32;
   localparam int SRAM_DATA_WD = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } arb_state_e;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_LS = 1'b1;

   function automatic logic own_is_if(input logic own);
      return (own == OWN_IF);
   endfunction

endpackage

// File: rtl/ysyx_22041752_arb_pick.sv
// Combinational winner selection between fetch and load/store.
// YSYX_22041752_ARB_RR_EN selects round-robin on ties; otherwise LS always wins ties.
module ysyx_22041752_arb_pick
   import ysyx_22041752_mem_arbiter_pkg::*;
(
   input  logic if_req_i,
   input  logic ls_req_i,
   input  logic last_own_i,
   output logic grant_any_o,
   output logic grant_own_o
);

   logic unused_last_s;
   assign unused_last_s = last_own_i;

   // Winner of the current IDLE cycle; if_req_i is already flush-qualified.
   always_comb begin
      grant_any_o = if_req_i | ls_req_i;
      grant_own_o = OWN_IF;
      if (if_req_i && ls_req_i) begin
`ifdef YSYX_22041752_ARB_RR_EN
         grant_own_o = own_is_if(last_own_i) ? OWN_LS : OWN_IF;
`else
         grant_own_o = OWN_LS;
`endif
      end else if (ls_req_i) begin
         grant_own_o = OWN_LS;
      end else begin
         grant_own_o = OWN_IF;
      end
   end

endmodule

// File: rtl/ysyx_22041752_mem_arbiter.sv
// Shares one SRAM-style memory port between IF and LS with a single outstanding
// transaction; tie policy follows YSYX_22041752_ARB_RR_EN (see ysyx_22041752_arb_pick).
module ysyx_22041752_mem_arbiter
   import ysyx_22041752_mem_arbiter_pkg::*;
#(
   parameter int ADDR_WD = SRAM_ADDR_WD,
   parameter int DATA_WD = SRAM_DATA_WD
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   if_req,
   input  logic [ADDR_WD-1:0]     if_addr,
   output logic                   if_ready,
   output logic                   if_rvalid,
   output logic [DATA_WD-1:0]     if_rdata,
   input  logic                   if_flush,
   input  logic                   ls_req,
   input  logic                   ls_wen,
   input  logic [ADDR_WD-1:0]     ls_addr,
   input  logic [DATA_WD-1:0]     ls_wdata,
   input  logic [DATA_WD/8-1:0]   ls_wstrb,
   output logic                   ls_ready,
   output logic                   ls_rvalid,
   output logic [DATA_WD-1:0]     ls_rdata,
   output logic                   mem_req,
   output logic                   mem_wen,
   output logic [ADDR_WD-1:0]     mem_addr,
   output logic [DATA_WD-1:0]     mem_wdata,
   output logic [DATA_WD/8-1:0]   mem_wstrb,
   input  logic                   mem_ready,
   input  logic                   mem_rvalid,
   input  logic [DATA_WD-1:0]     mem_rdata
);

   arb_state_e             state_q;
   logic                   owner_q;
   logic                   last_q;
   logic                   drop_q;
   logic                   drop_d;
   logic                   wen_q;
   logic [ADDR_WD-1:0]     addr_q;
   logic [DATA_WD-1:0]     wdata_q;
   logic [DATA_WD/8-1:0]   wstrb_q;

   logic                   if_req_ok_s;
   logic                   grant_any_s;
   logic                   grant_own_s;
   logic                   in_idle_s;
   logic                   in_wait_s;

   // A fetch flushed in the same cycle it asks is not worth starting.
   assign if_req_ok_s = if_req & ~if_flush;

   ysyx_22041752_arb_pick u_pick (
      .if_req_i    (if_req_ok_s),
      .ls_req_i    (ls_req),
      .last_own_i  (last_q),
      .grant_any_o (grant_any_s),
      .grant_own_o (grant_own_s)
   );

   assign in_idle_s = (state_q == ST_IDLE) & ~reset;
   assign in_wait_s = (state_q == ST_WAIT) & ~reset;

   assign if_ready  = in_idle_s & grant_any_s & own_is_if(grant_own_s);
   assign ls_ready  = in_idle_s & grant_any_s & ~own_is_if(grant_own_s);

   // A flush landing on the response cycle suppresses it just like a registered drop.
   assign if_rvalid = in_wait_s & mem_rvalid & own_is_if(owner_q) & ~drop_q & ~if_flush;
   assign ls_rvalid = in_wait_s & mem_rvalid & ~own_is_if(owner_q);
   assign if_rdata  = (in_wait_s && own_is_if(owner_q))  ? mem_rdata : '0;
   assign ls_rdata  = (in_wait_s && !own_is_if(owner_q)) ? mem_rdata : '0;

   assign mem_req   = (state_q == ST_REQ);
   assign mem_wen   = wen_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wstrb = wstrb_q;

   // Drop marks an accepted fetch whose data must not reach the IFU any more.
   always_comb begin
      drop_d = drop_q;
      if (state_q == ST_IDLE) begin
         drop_d = 1'b0;
      end else if (state_q == ST_WAIT && mem_rvalid) begin
         drop_d = 1'b0;
      end else if (own_is_if(owner_q) && if_flush) begin
         drop_d = 1'b1;
      end else begin
         drop_d = drop_q;
      end
   end

   // Transaction FSM plus the request latches it presents to memory.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         owner_q <= OWN_IF;
         last_q  <= OWN_IF;
         drop_q  <= 1'b0;
         wen_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
      end else begin
         drop_q <= drop_d;
         case (state_q)
            ST_IDLE: begin
               if (grant_any_s) begin
                  owner_q <= grant_own_s;
                  last_q  <= grant_own_s;
                  state_q <= ST_REQ;
                  if (own_is_if(grant_own_s)) begin
                     wen_q   <= 1'b0;
                     addr_q  <= if_addr;
                     wdata_q <= '0;
                     wstrb_q <= '0;
                  end else begin
                     wen_q   <= ls_wen;
                     addr_q  <= ls_addr;
                     wdata_q <= ls_wdata;
                     wstrb_q <= ls_wstrb;
                  end
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_REQ: begin
               // The request stays up even after a flush: memory may already own it.
               if (mem_ready) begin
                  state_q <= ST_WAIT;
               end else begin
                  state_q <= ST_REQ;
               end
            end
            ST_WAIT: begin
               if (mem_rvalid) begin
                  state_q <= ST_IDLE;
               end else begin
                  state_q <= ST_WAIT;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22041752_mem_arbiter.sv
// Scoreboard bench for ysyx_22041752_mem_arbiter with a latency-programmable memory model.
`timescale 1ns/1ps
module tb_ysyx_22041752_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 64;
   localparam int SW = DW/8;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_req, if_ready, if_rvalid, if_flush;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          ls_req, ls_wen, ls_ready, ls_rvalid;
   logic [AW-1:0] ls_addr;
   logic [DW-1:0] ls_wdata, ls_rdata;
   logic [SW-1:0] ls_wstrb;
   logic          mem_req, mem_wen, mem_ready, mem_rvalid;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [SW-1:0] mem_wstrb;

   always #5 clk = ~clk;

   ysyx_22041752_mem_arbiter #(.ADDR_WD(AW), .DATA_WD(DW)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata), .if_flush(if_flush),
      .ls_req(ls_req), .ls_wen(ls_wen), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_wstrb(ls_wstrb), .ls_ready(ls_ready), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata)
   );

   typedef struct packed {
      logic          own;
      logic [DW-1:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   if_pulses = 0;
   int   ls_pulses = 0;
   int   rv_cyc = -1;
   int   req_cyc = -1;
   int   mm_rv_cyc = -1;
   int   mm_st = 0;
   int   rdy_dly = 0;
   int   rsp_dly = 1;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
      if (a == 32'h8000_0000) return 64'h00000413_00000093;
      return {a ^ 32'hA5A5_5A5A, a};
   endfunction

   task automatic check_zero(input string tag);
      check_val({tag, "_ctl"}, 128'({mem_req, mem_wen, mem_addr, mem_wdata, mem_wstrb,
                                     if_ready, ls_ready, if_rvalid, ls_rvalid}), 128'(0));
      check_val({tag, "_rdata"}, {if_rdata, ls_rdata}, 128'(0));
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Memory model: ready after rdy_dly extra cycles, response rsp_dly cycles after ready.
   initial begin
      int            cnt;
      logic          wr;
      logic [DW-1:0] rd;
      logic [104:0]  hold;
      cnt = 0; wr = 1'b0; rd = '0; hold = '0;
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      forever begin
         @(posedge clk); #2;
         mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
         if (reset) begin
            mm_st = 0;
         end else begin
            case (mm_st)
               0: if (mem_req) begin
                  req_cyc = cyc;
                  hold = {mem_wen, mem_addr, mem_wdata, mem_wstrb};
                  wr = mem_wen;
                  rd = model_rd(mem_addr);
                  cnt = rdy_dly;
                  if (cnt == 0) begin
                     mem_ready = 1'b1; mm_st = 2; cnt = rsp_dly;
                  end else begin
                     mm_st = 1;
                  end
               end
               1: begin
                  check_val("mem_hold", 128'({mem_req, mem_wen, mem_addr, mem_wdata, mem_wstrb}),
                            128'({1'b1, hold}));
                  cnt--;
                  if (cnt == 0) begin
                     mem_ready = 1'b1; mm_st = 2; cnt = rsp_dly;
                  end
               end
               2: begin
                  cnt--;
                  if (cnt == 0) begin
                     mem_rvalid = 1'b1;
                     mem_rdata = wr ? 64'h0 : rd;
                     mm_st = 0;
                     mm_rv_cyc = cyc;
                  end
               end
               default: mm_st = 0;
            endcase
         end
      end
   end

   // Response monitor: every pulse must match the oldest expected entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (if_rvalid || ls_rvalid) begin
            rv_cyc = cyc;
            if (if_rvalid) if_pulses++;
            if (ls_rvalid) ls_pulses++;
            check_val("rv_onehot", 128'(if_rvalid & ls_rvalid), 128'(0));
            if (sb_q.size() == 0) begin
               check_val("rv_unexpected", 128'({if_rvalid, ls_rvalid}), 128'(0));
            end else begin
               e = sb_q.pop_front();
               check_val("rv_owner", 128'(ls_rvalid), 128'(e.own));
               check_val("rv_data", 128'(e.own ? ls_rdata : if_rdata), 128'(e.data));
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
      $fatal(1, "watchdog");
   end

   task automatic run_req(input bit do_if, input bit do_ls, output int first, output int g_cyc);
      bit got_if, got_ls;
      got_if = !do_if; got_ls = !do_ls; first = -1; g_cyc = -1;
      if_req = do_if; ls_req = do_ls;
      for (int i = 0; i < 80 && !(got_if && got_ls); i++) begin
         @(negedge clk);
         if (if_ready && !got_if) begin
            got_if = 1'b1;
            if (first < 0) begin first = 0; g_cyc = cyc; end
         end
         if (ls_ready && !got_ls) begin
            got_ls = 1'b1;
            if (first < 0) begin first = 1; g_cyc = cyc; end
         end
         @(posedge clk); #1;
         if (got_if) if_req = 1'b0;
         if (got_ls) ls_req = 1'b0;
      end
      if (!(got_if && got_ls)) check_val("grant_timeout", 128'({got_if, got_ls}), 128'(2'b11));
      if_req = 1'b0; ls_req = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #1;
         if (sb_q.size() == 0 && mm_st == 0) break;
      end
      check_val(tag, 128'(sb_q.size()), 128'(0));
      @(posedge clk); #1;
   endtask

   initial begin
      int first, g, g2, p_if, p_ls, fc;
      reset = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
      ls_req = 1'b0; ls_wen = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wstrb = '0;
      repeat (3) @(posedge clk);
      @(negedge clk); check_zero("rst_in");
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk); check_zero("rst_out");
      @(posedge clk); #1;

      // Single fetch, minimum latency.
      p_ls = ls_pulses;
      if_addr = 32'h8000_0000;
      sb_q.push_back('{own: 1'b0, data: 64'h00000413_00000093});
      run_req(1'b1, 1'b0, first, g);
      check_val("f1_owner", 128'(first), 128'(0));
      wait_drain("f1_drain");
      check_val("f1_mem_req_cyc", 128'(req_cyc), 128'(g + 1));
      check_val("f1_rvalid_cyc", 128'(rv_cyc), 128'(g + 2));
      check_val("f1_ls_quiet", 128'(ls_pulses), 128'(p_ls));

      // Fetch in IDLE together with flush is not granted.
      if_req = 1'b1; if_flush = 1'b1;
      @(negedge clk); check_val("flush_gate_ready", 128'(if_ready), 128'(0));
      @(posedge clk); #1; if_req = 1'b0; if_flush = 1'b0;
      @(negedge clk); check_val("flush_gate_req", 128'(mem_req), 128'(0));
      @(posedge clk); #1;

      // Tie: LS wins first under both policies.
      if_addr = 32'h8000_0040; ls_wen = 1'b0; ls_addr = 32'h8000_1000;
      sb_q.push_back('{own: 1'b1, data: model_rd(32'h8000_1000)});
      sb_q.push_back('{own: 1'b0, data: model_rd(32'h8000_0040)});
      run_req(1'b1, 1'b1, first, g);
      check_val("tie1_first", 128'(first), 128'(1));
      wait_drain("tie1_drain");

      // LS alone, then another tie: round-robin now favours IF.
      ls_addr = 32'h8000_1008;
      sb_q.push_back('{own: 1'b1, data: model_rd(32'h8000_1008)});
      run_req(1'b0, 1'b1, first, g);
      wait_drain("ls1_drain");
      if_addr = 32'h8000_0080; ls_addr = 32'h8000_1010;
`ifdef YSYX_22041752_ARB_RR_EN
      sb_q.push_back('{own: 1'b0, data: model_rd(32'h8000_0080)});
      sb_q.push_back('{own: 1'b1, data: model_rd(32'h8000_1010)});
      run_req(1'b1, 1'b1, first, g);
      check_val("tie2_first", 128'(first), 128'(0));
`else
      sb_q.push_back('{own: 1'b1, data: model_rd(32'h8000_1010)});
      sb_q.push_back('{own: 1'b0, data: model_rd(32'h8000_0080)});
      run_req(1'b1, 1'b1, first, g);
      check_val("tie2_first", 128'(first), 128'(1));
`endif
      wait_drain("tie2_drain");

      // Store with delayed mem_ready; hold checks run inside the memory model.
      rdy_dly = 3; p_ls = ls_pulses;
      ls_wen = 1'b1; ls_addr = 32'h8000_2000; ls_wdata = 64'hDEADBEEF; ls_wstrb = 8'h0F;
      sb_q.push_back('{own: 1'b1, data: 64'h0});
      run_req(1'b0, 1'b1, first, g);
      wait_drain("st_drain");
      check_val("st_pulses", 128'(ls_pulses), 128'(p_ls + 1));
      check_val("st_req_cyc", 128'(req_cyc), 128'(g + 1));
      rdy_dly = 0; ls_wen = 1'b0; ls_wstrb = '0; ls_wdata = '0;

      // Flush during WAIT drops the fetch; the next fetch is granted right after.
      rsp_dly = 3; p_if = if_pulses;
      if_addr = 32'h8000_0100;
      run_req(1'b1, 1'b0, first, g);
      @(posedge clk); #1; if_flush = 1'b1;
      @(posedge clk); #1; if_flush = 1'b0;
      if_addr = 32'h8000_0200;
      sb_q.push_back('{own: 1'b0, data: model_rd(32'h8000_0200)});
      run_req(1'b1, 1'b0, first, g2);
      check_val("fl_regrant_cyc", 128'(g2), 128'(mm_rv_cyc + 1));
      wait_drain("fl_drain");
      check_val("fl_if_pulses", 128'(if_pulses), 128'(p_if + 1));

      // Flush on the very cycle of mem_rvalid.
      rsp_dly = 2; p_if = if_pulses;
      if_addr = 32'h8000_0300;
      run_req(1'b1, 1'b0, first, g);
      @(posedge clk); #1;
      @(posedge clk); #1; if_flush = 1'b1; fc = cyc;
      @(posedge clk); #1; if_flush = 1'b0;
      wait_drain("co_drain");
      check_val("co_rv_cyc", 128'(mm_rv_cyc), 128'(fc));
      check_val("co_if_pulses", 128'(if_pulses), 128'(p_if));

      // Flush while LS owns has no effect.
      p_ls = ls_pulses; ls_addr = 32'h8000_3000;
      sb_q.push_back('{own: 1'b1, data: model_rd(32'h8000_3000)});
      run_req(1'b0, 1'b1, first, g);
      if_flush = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1; if_flush = 1'b0;
      wait_drain("lsfl_drain");
      check_val("lsfl_pulses", 128'(ls_pulses), 128'(p_ls + 1));

      // Reset during WAIT abandons the transaction.
      rsp_dly = 4; p_if = if_pulses;
      if_addr = 32'h8000_0400;
      run_req(1'b1, 1'b0, first, g);
      @(posedge clk); #1; reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk); check_zero("mid_rst");
      repeat (6) @(posedge clk);
      #1;
      check_val("mid_rst_pulses", 128'(if_pulses), 128'(p_if));
      rsp_dly = 1;
      if_addr = 32'h8000_0000;
      sb_q.push_back('{own: 1'b0, data: 64'h00000413_00000093});
      run_req(1'b1, 1'b0, first, g);
      wait_drain("post_rst_drain");
      check_val("post_rst_rv_cyc", 128'(rv_cyc), 128'(g + 2));

      check_val("sb_empty", 128'(sb_q.size()), 128'(0));
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
